// File: rtl/cutoff_update_sequencer.sv
// Cutoff-frequency update sequencer.
// Turns each envelope-average strobe into a clamped, slew-limited cutoff value
// for the filter-coefficient stage. One shared 24x24 multiplier is reused over
// two cycles. Samples that arrive while busy wait in a 1-deep pending buffer.
module cutoff_update_sequencer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FC_MAX       = 1024,
  parameter int FC_MIN       = 69,
  parameter int FC_CLAMP_HI  = 4194304,
  parameter int SLEW_STEP    = 65536
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    env_valid,
  input  logic [SAMPLE_WIDTH-1:0] env_avg,
  input  logic [3:0]              filter_strength_ratio,
  output logic                    fc_valid,
  input  logic                    fc_ready,
  output logic [SAMPLE_WIDTH-1:0] cutoff_freq,
  output logic                    busy,
  output logic [7:0]              drop_count
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int PW = 2 * SAMPLE_WIDTH;

  localparam logic [W-1:0] FC_MIN_W      = W'(FC_MIN);
  localparam logic [W-1:0] FC_MAX_W      = W'(FC_MAX);
  localparam logic [W-1:0] FC_CLAMP_HI_W = W'(FC_CLAMP_HI);
  localparam logic [W-1:0] SLEW_STEP_W   = W'(SLEW_STEP);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL1    = 3'd1,
    ST_MUL2    = 3'd2,
    ST_CLAMP   = 3'd3,
    ST_SLEW    = 3'd4,
    ST_PRESENT = 3'd5
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Working copy of the sample being processed.
  logic [W-1:0] work_env_reg;
  logic [3:0]   work_ratio_reg;

  // Holds p1 after MUL1, then p2 after MUL2.
  logic [W-1:0] prod_reg;
  logic [W-1:0] target_reg;
  logic [W-1:0] cutoff_reg;

  // 1-deep pending buffer for samples arriving while busy.
  logic         pend_valid_reg;
  logic [W-1:0] pend_env_reg;
  logic [3:0]   pend_ratio_reg;
  logic [7:0]   drop_count_reg;

  // Shared multiplier signals.
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [PW-1:0] mul_full;
  logic [W-1:0]  mul_sat;

  logic [W-1:0] target_next;
  logic [W-1:0] slew_next;
  logic [W-1:0] slew_diff;

  logic start_capture;
  logic take_live;

  assign start_capture = (state_reg == ST_IDLE) && (env_valid || pend_valid_reg);
  // Live strobe wins over the pending entry when both are present.
  assign take_live     = env_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: fixed one-cycle compute states, PRESENT waits for ready.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (env_valid || pend_valid_reg) state_next = ST_MUL1;
      ST_MUL1:    state_next = ST_MUL2;
      ST_MUL2:    state_next = ST_CLAMP;
      ST_CLAMP:   state_next = ST_SLEW;
      ST_SLEW:    state_next = ST_PRESENT;
      ST_PRESENT: if (fc_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Operand steering for the shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      ST_MUL1: begin
        mul_a = W'(work_env_reg >> 8);
        mul_b = W'({work_ratio_reg, 12'b0});
      end
      ST_MUL2: begin
        mul_a = prod_reg;
        mul_b = FC_MAX_W;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign mul_full = PW'(mul_a) * PW'(mul_b);

  // Any bit above the sample width forces the product to full scale.
  always_comb begin
    mul_sat = mul_full[W-1:0];
    if (|mul_full[PW-1:W]) begin
      mul_sat = '1;
    end
  end

  // Target selection: zero strength means bypass target, otherwise clamp p2.
  always_comb begin
    target_next = prod_reg;
    if (work_ratio_reg == 4'd0) begin
      target_next = FC_MIN_W;
    end else if (prod_reg > FC_CLAMP_HI_W) begin
      target_next = FC_CLAMP_HI_W;
    end else if (prod_reg < FC_MIN_W) begin
      target_next = FC_MIN_W;
    end
  end

  // Slew limiter: jump to target when close, otherwise move one step toward it.
  always_comb begin
    slew_diff = '0;
    slew_next = cutoff_reg;
    if (target_reg >= cutoff_reg) begin
      slew_diff = target_reg - cutoff_reg;
      if (slew_diff <= SLEW_STEP_W) begin
        slew_next = target_reg;
      end else begin
        slew_next = cutoff_reg + SLEW_STEP_W;
      end
    end else begin
      slew_diff = cutoff_reg - target_reg;
      if (slew_diff <= SLEW_STEP_W) begin
        slew_next = target_reg;
      end else begin
        slew_next = cutoff_reg - SLEW_STEP_W;
      end
    end
  end

  // Datapath: capture, two multiply passes, clamp, slew.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_env_reg   <= '0;
      work_ratio_reg <= '0;
      prod_reg       <= '0;
      target_reg     <= FC_MIN_W;
      cutoff_reg     <= FC_MIN_W;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_capture) begin
            work_env_reg   <= take_live ? env_avg : pend_env_reg;
            work_ratio_reg <= take_live ? filter_strength_ratio : pend_ratio_reg;
          end
        end
        ST_MUL1:  prod_reg   <= mul_sat;
        ST_MUL2:  prod_reg   <= mul_sat;
        ST_CLAMP: target_reg <= target_next;
        ST_SLEW:  cutoff_reg <= slew_next;
        default:  ;
      endcase
    end
  end

  // Pending buffer and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_reg <= 1'b0;
      pend_env_reg   <= '0;
      pend_ratio_reg <= '0;
      drop_count_reg <= '0;
    end else if (state_reg == ST_IDLE) begin
      // In IDLE the pending entry is either consumed or displaced by a live strobe.
      pend_valid_reg <= 1'b0;
      if (env_valid && pend_valid_reg && (drop_count_reg != 8'hFF)) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end else if (env_valid) begin
      pend_valid_reg <= 1'b1;
      pend_env_reg   <= env_avg;
      pend_ratio_reg <= filter_strength_ratio;
      if (pend_valid_reg && (drop_count_reg != 8'hFF)) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  assign fc_valid    = (state_reg == ST_PRESENT);
  assign busy        = (state_reg != ST_IDLE);
  assign cutoff_freq = cutoff_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_cutoff_update_sequencer.sv
// Testbench for cutoff_update_sequencer: directed scenarios plus randomized
// samples checked against an arithmetic reference model.
module tb_cutoff_update_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        env_valid;
  logic [23:0] env_avg;
  logic [3:0]  filter_strength_ratio;
  logic        fc_valid;
  logic        fc_ready;
  logic [23:0] cutoff_freq;
  logic        busy;
  logic [7:0]  drop_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [23:0] model_cutoff;
  int          exp_drop;

  cutoff_update_sequencer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .env_valid             (env_valid),
    .env_avg               (env_avg),
    .filter_strength_ratio (filter_strength_ratio),
    .fc_valid              (fc_valid),
    .fc_ready              (fc_ready),
    .cutoff_freq           (cutoff_freq),
    .busy                  (busy),
    .drop_count            (drop_count)
  );

  always #5 clk = ~clk;

  // Reference: next presented cutoff from a sample and the current cutoff.
  function automatic logic [23:0] model_next(input logic [23:0] e, input logic [3:0] r,
                                             input logic [23:0] cur);
    longint p1, p2, tgt, c;
    p1 = longint'(e / 256) * (longint'(r) * 4096);
    if (p1 > 16777215) p1 = 16777215;
    p2 = p1 * 1024;
    if (p2 > 16777215) p2 = 16777215;
    if (r == 0) tgt = 69;
    else begin
      tgt = (p2 < 4194304) ? p2 : 4194304;
      if (tgt < 69) tgt = 69;
    end
    c = longint'(cur);
    if (tgt > c + 65536) c = c + 65536;
    else if (tgt < c - 65536) c = c - 65536;
    else c = tgt;
    return 24'(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe one sample, wait for fc_valid, hold ready low for 'hold' cycles, then accept.
  task automatic run_update(input logic [23:0] e, input logic [3:0] r, input int hold,
                            output int lat, output logic [23:0] cf, output bit unstable);
    env_avg = e;
    filter_strength_ratio = r;
    env_valid = 1'b1;
    fc_ready = (hold == 0);
    lat = 0;
    unstable = 0;
    do begin
      tick();
      env_valid = 1'b0;
      // Inputs wander after capture; the result must not depend on them.
      env_avg = 24'($urandom);
      filter_strength_ratio = 4'($urandom);
      lat++;
    end while (!fc_valid && lat < 40);
    cf = cutoff_freq;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!fc_valid || cutoff_freq !== cf) unstable = 1;
    end
    fc_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    env_valid = 1'b0;
    env_avg = '0;
    filter_strength_ratio = '0;
    fc_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (cutoff_freq !== 24'd69) begin
      tests_failed++;
      $display("FAIL reset_cutoff: got %0d expected 69", cutoff_freq);
    end
    tests_run++;
    if (fc_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: fc_valid=%b busy=%b expected 0 0", fc_valid, busy);
    end
    tests_run++;
    if (drop_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_drop: got %0d expected 0", drop_count);
    end
    model_cutoff = 24'd69;
    exp_drop = 0;
    $display("[TB] reset: cutoff=%0d fc_valid=%b busy=%b drop=%0d", cutoff_freq, fc_valid, busy, drop_count);
  endtask

  task automatic test_latency();
    int lat;
    logic [23:0] cf;
    bit unst;
    run_update(24'd256, 4'd1, 0, lat, cf, unst);
    model_cutoff = model_next(24'd256, 4'd1, model_cutoff);
    tests_run++;
    if (lat !== 5) begin
      tests_failed++;
      $display("FAIL latency: fc_valid after %0d cycles expected 5", lat);
    end
    tests_run++;
    if (cf !== 24'd65605) begin
      tests_failed++;
      $display("FAIL first_step: cutoff=%0d expected 65605", cf);
    end
    tests_run++;
    if (fc_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pulse: fc_valid=%b busy=%b after accept expected 0 0", fc_valid, busy);
    end
    $display("[TB] latency: lat=%0d cutoff=%0d", lat, cf);
  endtask

  task automatic test_ramp();
    int lat;
    logic [23:0] cf;
    logic [23:0] prev;
    bit unst;
    prev = cutoff_freq;
    for (int k = 0; k < 63; k++) begin
      prev = cutoff_freq;
      run_update(24'd256, 4'd1, 0, lat, cf, unst);
      model_cutoff = model_next(24'd256, 4'd1, model_cutoff);
      tests_run++;
      if (cf !== model_cutoff || lat !== 5) begin
        tests_failed++;
        $display("FAIL ramp_%0d: cutoff=%0d lat=%0d expected %0d lat 5", k, cf, lat, model_cutoff);
      end
    end
    tests_run++;
    if (prev !== 24'd4128837 || cutoff_freq !== 24'd4194304) begin
      tests_failed++;
      $display("FAIL ramp_final: prev=%0d final=%0d expected 4128837 4194304", prev, cutoff_freq);
    end
    $display("[TB] ramp: prev=%0d final=%0d", prev, cutoff_freq);
  endtask

  task automatic test_zero_strength();
    int lat;
    logic [23:0] cf;
    bit unst;
    logic [23:0] e;
    e = 24'($urandom);
    run_update(e, 4'd0, 0, lat, cf, unst);
    model_cutoff = model_next(e, 4'd0, model_cutoff);
    tests_run++;
    if (cf !== 24'd4128768) begin
      tests_failed++;
      $display("FAIL zero_from_top: cutoff=%0d expected 4128768", cf);
    end
    for (int k = 0; k < 64; k++) begin
      e = 24'($urandom);
      run_update(e, 4'd0, 0, lat, cf, unst);
      model_cutoff = model_next(e, 4'd0, model_cutoff);
    end
    tests_run++;
    if (cf !== 24'd69 || cf !== model_cutoff) begin
      tests_failed++;
      $display("FAIL zero_settle: cutoff=%0d expected 69", cf);
    end
    $display("[TB] zero_strength: cutoff=%0d", cf);
  endtask

  task automatic test_saturation();
    int lat;
    logic [23:0] cf;
    bit unst;
    run_update(24'hFFFFFF, 4'd15, 0, lat, cf, unst);
    model_cutoff = model_next(24'hFFFFFF, 4'd15, model_cutoff);
    tests_run++;
    if (cf !== 24'd65605) begin
      tests_failed++;
      $display("FAIL saturation: cutoff=%0d expected 65605", cf);
    end
    $display("[TB] saturation: cutoff=%0d", cf);
  endtask

  task automatic test_backpressure();
    int lat;
    int pulses;
    logic [23:0] cf;
    logic [23:0] ea, ed;
    logic [3:0]  ra, rd;
    bit unst;
    ea = 24'($urandom);
    ra = 4'($urandom_range(1, 15));
    env_avg = ea;
    filter_strength_ratio = ra;
    env_valid = 1'b1;
    fc_ready = 1'b0;
    lat = 0;
    do begin
      tick();
      env_valid = 1'b0;
      lat++;
    end while (!fc_valid && lat < 40);
    model_cutoff = model_next(ea, ra, model_cutoff);
    cf = cutoff_freq;
    tests_run++;
    if (cf !== model_cutoff || lat !== 5) begin
      tests_failed++;
      $display("FAIL bp_first: cutoff=%0d lat=%0d expected %0d lat 5", cf, lat, model_cutoff);
    end
    unst = 0;
    ed = '0;
    rd = '0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 8) begin
        env_avg = 24'($urandom);
        filter_strength_ratio = 4'($urandom);
        ed = env_avg;
        rd = filter_strength_ratio;
        env_valid = 1'b1;
      end else begin
        env_valid = 1'b0;
      end
      tick();
      if (!fc_valid || cutoff_freq !== cf) unst = 1;
    end
    env_valid = 1'b0;
    exp_drop += 2;
    tests_run++;
    if (unst) begin
      tests_failed++;
      $display("FAIL bp_hold: fc_valid=%b cutoff=%0d expected 1 %0d", fc_valid, cutoff_freq, cf);
    end
    tests_run++;
    if (drop_count !== 8'(exp_drop)) begin
      tests_failed++;
      $display("FAIL bp_drop: got %0d expected %0d", drop_count, exp_drop);
    end
    fc_ready = 1'b1;
    tick();
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!fc_valid && lat < 40);
    model_cutoff = model_next(ed, rd, model_cutoff);
    tests_run++;
    if (cutoff_freq !== model_cutoff || lat !== 5) begin
      tests_failed++;
      $display("FAIL bp_pending: cutoff=%0d lat=%0d expected %0d lat 5", cutoff_freq, lat, model_cutoff);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fc_valid) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL bp_no_extra: %0d extra fc_valid cycles expected 0", pulses);
    end
    $display("[TB] backpressure: drop=%0d pending_cutoff=%0d", drop_count, model_cutoff);
  endtask

  task automatic test_random();
    int lat;
    logic [23:0] cf;
    bit unst;
    logic [23:0] e;
    logic [3:0]  r;
    int hold;
    for (int k = 0; k < 30; k++) begin
      e = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 4096));
      r = 4'($urandom);
      hold = $urandom_range(0, 3);
      run_update(e, r, hold, lat, cf, unst);
      model_cutoff = model_next(e, r, model_cutoff);
      tests_run++;
      if (cf !== model_cutoff || lat !== 5 || unst) begin
        tests_failed++;
        $display("FAIL random_%0d: env=%0d ratio=%0d cutoff=%0d lat=%0d unstable=%0d expected %0d lat 5 stable",
                 k, e, r, cf, lat, unst, model_cutoff);
      end else begin
        $display("[TB] random_%0d: env=%0d ratio=%0d cutoff=%0d", k, e, r, cf);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    env_avg = 24'd256;
    filter_strength_ratio = 4'd3;
    env_valid = 1'b1;
    fc_ready = 1'b1;
    tick();
    env_avg = 24'd9000;
    env_valid = 1'b1;
    tick();
    env_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_busy: busy=%b expected 1", busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if (fc_valid !== 1'b0 || busy !== 1'b0 || cutoff_freq !== 24'd69 || drop_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_state: fc_valid=%b busy=%b cutoff=%0d drop=%0d expected 0 0 69 0",
               fc_valid, busy, cutoff_freq, drop_count);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fc_valid || busy) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL rst_mid_quiet: %0d active cycles after reset expected 0", pulses);
    end
    model_cutoff = 24'd69;
    exp_drop = 0;
    $display("[TB] reset_mid: cutoff=%0d active_cycles=%0d", cutoff_freq, pulses);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ramp();
    test_zero_strength();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cutoff_update_sequencer.md
Name: cutoff_update_sequencer

Overview:
- Sequences per-sample cutoff-frequency updates for the envelope-controlled filter.
- On each envelope-average strobe, computes cutoff = (env_avg >> 8) * (strength * 4096) * FC_MAX using one shared 24x24 multiplier over two cycles.
- Clamps and slew-limits the result, then presents it to the filter-coefficient stage over a valid/ready handshake.
- Sits between the envelope averager and the filter core.

Parameters:
- SAMPLE_WIDTH, 24, width of env_avg and cutoff values
- FC_MAX, 1024, final multiplier constant
- FC_MIN, 69, lower clamp, reset cutoff, and zero-strength target
- FC_CLAMP_HI, 4194304, upper clamp on target
- SLEW_STEP, 65536, maximum change of the presented cutoff per update

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- env_valid  input  1  one-cycle strobe: env_avg is a new value
- env_avg  input  SAMPLE_WIDTH  envelope average, unsigned
- filter_strength_ratio  input  4  strength; 0 means filter bypass target
- fc_valid  output  1  cutoff_freq is valid
- fc_ready  input  1  downstream accepts cutoff_freq
- cutoff_freq  output  SAMPLE_WIDTH  slewed cutoff
- busy  output  1  FSM not in IDLE
- drop_count  output  8  saturating count of overwritten pending samples

Behaviour:
- Reset (rst_n low at a clk edge) sets:
  - FSM to IDLE; fc_valid=0; cutoff_freq=FC_MIN; busy=0; drop_count=0; pending buffer empty.
  - Reset mid-operation aborts any computation; no partial result is presented.
- States: IDLE -> MUL1 -> MUL2 -> CLAMP -> SLEW -> PRESENT -> IDLE. Each state lasts 1 cycle except PRESENT, which holds until fc_ready.
- IDLE:
  - If env_valid or the pending buffer is full, capture env_avg and filter_strength_ratio into working registers and go to MUL1.
  - Live env_valid has priority over pending. If both are present, the pending entry is overwritten, drop_count is incremented, and the live value is captured.
- MUL1: p1 = sat24((env>>8) * (ratio*4096)). The full-width product saturates to 24'hFFFFFF.
- MUL2: p2 = sat24(p1 * FC_MAX). Same shared multiplier.
- CLAMP:
  - target = FC_MIN if ratio==0.
  - Otherwise target = max(FC_MIN, min(p2, FC_CLAMP_HI)).
- SLEW:
  - next = target if |target - cutoff_freq| <= SLEW_STEP.
  - Otherwise next = cutoff_freq ± SLEW_STEP toward target.
  - cutoff_freq updates at the end of SLEW.
- PRESENT:
  - fc_valid=1; cutoff_freq stable.
  - On fc_valid & fc_ready: fc_valid drops next cycle and FSM goes to IDLE.
- Latency: env_valid at cycle 0 gives fc_valid=1 at cycle 5 (four compute cycles). With fc_ready held high, fc_valid is high for exactly 1 cycle and the next sample can be captured at cycle 6.
- env_valid while busy (any state except IDLE):
  - Store the sample in the 1-deep pending buffer (env_avg + ratio).
  - If the buffer is already full, overwrite it and drop_count += 1, saturating at 255.
  - The pending sample is processed directly after return to IDLE, with no idle gap required.
- Strength ratio is sampled only at capture; changes mid-computation have no effect on the current result.
- cutoff_freq changes only at the SLEW state, never while fc_valid=1.
- busy = (state != IDLE).

Test Plan:
- Reset, then idle: cutoff_freq=69, fc_valid=0, busy=0, drop_count=0.
- env_avg=256, ratio=1, fc_ready=1: p2=4194304, target=4194304; fc_valid exactly at cycle 5 with cutoff_freq=65605 (69+65536).
- Repeat the same sample 64 times: cutoff_freq steps by 65536 each update and settles at 4194304. The final step is exactly the remainder.
- ratio=0, any env_avg, starting from cutoff 69: cutoff_freq=69. Starting from 4194304: the next update gives 4128768.
- env_avg=24'hFFFFFF, ratio=15: both products saturate, target clamps to 4194304.
- fc_ready=0 for 10 cycles with three env_valid strobes during that time:
  - fc_valid held, cutoff_freq stable.
  - drop_count=2; only the last strobe's sample is processed after acceptance.
- Assert rst_n=0 during MUL2: next cycle outputs are at reset values, and no fc_valid pulse appears afterward.
